// File: rtl/ps2_rx_hub.sv
// rtl/ps2_rx_hub.sv - NCH-channel PS/2 host receiver with per-channel FIFOs and round-robin merge
// Optional feature macro: PS2_HUB_INHIBIT_EN (hold ps2 clock low while a channel FIFO is nearly full)
module ps2_rx_hub #(
  parameter  int NCH         = 2,
  parameter  int DEPTH       = 8,
  parameter  int FILT_LEN    = 8,
  parameter  int TIMEOUT_CYC = 5000,
  localparam int CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   ps2_clk_i,
  input  logic [NCH-1:0]   ps2_data_i,
  output logic [NCH-1:0]   ps2_clk_oe,
  output logic [NCH-1:0]   ps2_data_oe,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [CHW-1:0]   out_chan,
  output logic [NCH-1:0]   err_sticky,
  output logic [NCH-1:0]   ovf_sticky,
  input  logic [NCH-1:0]   sticky_clr,
  output logic [NCH*4-1:0] fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

  logic [NCH-1:0] fifo_empty;
  logic [7:0]     fifo_head [NCH];
  logic [NCH-1:0] pop;

  assign ps2_data_oe = '0;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [1:0]    clk_sync, dat_sync;
    logic          clk_f, clk_f_d, dat_f;
    logic [FW-1:0] clk_cnt, dat_cnt;
    logic          fall;
    rx_state_t     state;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tmr;
    logic          good, push, timeout, frame_err, wr_en;
    logic          err_q, ovf_q;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   count32;

    // Two-flop synchroniser followed by a run-length filter on both lines; idle bus is high
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        clk_sync <= 2'b11;
        dat_sync <= 2'b11;
        clk_f    <= 1'b1;
        clk_f_d  <= 1'b1;
        dat_f    <= 1'b1;
        clk_cnt  <= '0;
        dat_cnt  <= '0;
      end else begin
        clk_sync <= {clk_sync[0], ps2_clk_i[c]};
        dat_sync <= {dat_sync[0], ps2_data_i[c]};
        clk_f_d  <= clk_f;
        if (clk_sync[1] == clk_f) clk_cnt <= '0;
        else if (clk_cnt == FW'(FILT_LEN - 1)) begin
          clk_f   <= clk_sync[1];
          clk_cnt <= '0;
        end else clk_cnt <= clk_cnt + 1'b1;
        if (dat_sync[1] == dat_f) dat_cnt <= '0;
        else if (dat_cnt == FW'(FILT_LEN - 1)) begin
          dat_f   <= dat_sync[1];
          dat_cnt <= '0;
        end else dat_cnt <= dat_cnt + 1'b1;
      end
    end

    assign fall      = clk_f_d & ~clk_f;
    assign good      = dat_f & (^{shreg, par});
    assign push      = fall && (state == S_STOP) && good;
    assign timeout   = (state != S_IDLE) && !fall && (tmr == TW'(TIMEOUT_CYC - 1));
    assign frame_err = (fall && (state == S_STOP) && !good) || timeout;
    assign wr_en     = push && (count != (AW+1)'(DEPTH));

    // Frame decoder: start, 8 data bits LSB first, parity, stop; inter-edge timer aborts stalled frames
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= S_IDLE;
        bit_idx <= '0;
        shreg   <= '0;
        par     <= 1'b0;
        tmr     <= '0;
      end else begin
        if (fall || state == S_IDLE) tmr <= '0;
        else                         tmr <= tmr + 1'b1;
        case (state)
          S_IDLE:   if (fall && !dat_f) begin
                      state   <= S_DATA;
                      bit_idx <= '0;
                    end
          S_DATA:   if (fall) begin
                      shreg   <= {dat_f, shreg[7:1]};
                      bit_idx <= bit_idx + 1'b1;
                      if (bit_idx == 3'd7) state <= S_PARITY;
                    end
          S_PARITY: if (fall) begin
                      par   <= dat_f;
                      state <= S_STOP;
                    end
          S_STOP:   if (fall) state <= S_IDLE;
          default:  state <= S_IDLE;
        endcase
        if (timeout) state <= S_IDLE;
      end
    end

    // FIFO storage; contents need no reset because occupancy is tracked separately
    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= shreg;
    end

    // FIFO pointers, occupancy and sticky flags (a set in the same cycle as a clear wins)
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        err_q  <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
        if (pop[c]) rd_ptr <= rd_ptr + 1'b1;
        count <= count + (AW+1)'(wr_en) - (AW+1)'(pop[c]);
        err_q <= frame_err | (err_q & ~sticky_clr[c]);
        ovf_q <= (push & ~wr_en) | (ovf_q & ~sticky_clr[c]);
      end
    end

    assign count32       = 32'(count);
    assign fifo_empty[c] = (count == '0);
    assign fifo_head[c]  = mem[rd_ptr];
    assign err_sticky[c] = err_q;
    assign ovf_sticky[c] = ovf_q;
    assign fifo_level[4*c +: 4] = (count32 > 32'd15) ? 4'd15 : count32[3:0];

`ifdef PS2_HUB_INHIBIT_EN
    logic oe_q;
    // Inhibit the device between frames while the FIFO is one entry from full
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) oe_q <= 1'b0;
      else        oe_q <= (count >= (AW+1)'(DEPTH - 1)) && (state == S_IDLE);
    end
    assign ps2_clk_oe[c] = oe_q;
`else
    assign ps2_clk_oe[c] = 1'b0;
`endif
  end

  logic [CHW-1:0] last, pick;
  logic           found, load;

  // Round-robin search starting at the channel after the last one granted
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = last;
    pop   = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = (int'(last) + i) % NCH;
      if (!found && !fifo_empty[idx]) begin
        found = 1'b1;
        pick  = CHW'(idx);
      end
    end
    load = found && (!out_valid || out_ready);
    if (load) pop[pick] = 1'b1;
  end

  // Output register: reloads on accept without a bubble, holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      last      <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= fifo_head[pick];
      out_chan  <= pick;
      last      <= pick;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ps2_rx_hub.sv
// tb/tb_ps2_rx_hub.sv - directed self-checking bench for ps2_rx_hub with a per-channel byte model
module tb_ps2_rx_hub;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ps2_clk_i = 2'b11;
  logic [1:0] ps2_data_i = 2'b11;
  logic       out_ready = 1'b0;
  logic [1:0] sticky_clr = 2'b00;
  logic [1:0] ps2_clk_oe, ps2_data_oe, err_sticky, ovf_sticky;
  logic       out_valid;
  logic [7:0] out_data;
  logic [0:0] out_chan;
  logic [7:0] fifo_level;

  ps2_rx_hub dut (
    .clk(clk), .rst_n(rst_n),
    .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chan(out_chan),
    .err_sticky(err_sticky), .ovf_sticky(ovf_sticky),
    .sticky_clr(sticky_clr), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int rise_cyc = -1;
  logic [8:0] exp_q[$];
  logic [1:0] exp_err = 2'b00;
  logic [1:0] exp_ovf = 2'b00;
  logic [7:0] got_data[$];
  int         got_cyc[$];
  logic       prev_valid = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [0:0] prev_chan = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Model: each channel delivers its good bytes in order; a channel can hold DEPTH bytes in its
  // FIFO plus one in the output register, further bytes are dropped and flag overflow
  task automatic model_push(input int ch, input logic [7:0] d);
    int n;
    n = 0;
    foreach (exp_q[i]) if (exp_q[i][8] == ch[0]) n++;
    if (n >= DEPTH + 1) exp_ovf[ch] = 1'b1;
    else exp_q.push_back({ch[0], d});
  endtask

  // Compare process: every handshake against the model, and stability while stalled
  always @(negedge clk) begin : cmp
    int idx;
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_chan", out_chan, prev_chan);
      end
      if (out_valid && !prev_valid) rise_cyc = cyc;
      if (out_valid && out_ready) begin
        idx = -1;
        foreach (exp_q[i]) if (idx < 0 && exp_q[i][8] == out_chan[0]) idx = i;
        total++;
        if (idx < 0) begin
          bad++;
          $display("FAIL stream_unexpected actual=chan%0d:%0h required=none", out_chan, out_data);
        end else begin
          if (exp_q[idx][7:0] !== out_data) begin
            bad++;
            $display("FAIL stream_data actual=%0h required=%0h", out_data, exp_q[idx][7:0]);
          end
          exp_q.delete(idx);
        end
        got_data.push_back(out_data);
        got_cyc.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      prev_valid = out_valid;
      prev_data  = out_data;
      prev_chan  = out_chan;
    end
  end

  task automatic send_bit(input int ch, input logic b, input bit clr);
    ps2_data_i[ch] = b;
    repeat (20) tick();
    ps2_clk_i[ch] = 1'b0;
    stop_cyc = cyc;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (clr && i == 9)  sticky_clr[ch] = 1'b1;
      if (clr && i == 10) sticky_clr[ch] = 1'b0;
    end
    ps2_clk_i[ch] = 1'b1;
  endtask

  task automatic send_frame(input int ch, input logic [7:0] d, input bit bad_par,
                            input bit bad_stop, input bit clr);
    logic p;
    p = (~^d) ^ bad_par;
    send_bit(ch, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(ch, d[i], 1'b0);
    send_bit(ch, p, 1'b0);
    if (bad_par || bad_stop) exp_err[ch] = 1'b1;
    else model_push(ch, d);
    send_bit(ch, ~bad_stop, clr);
    ps2_data_i[ch] = 1'b1;
    repeat (20) tick();
  endtask

  task automatic pulse_clr(input logic [1:0] m);
    sticky_clr = m;
    tick();
    sticky_clr = 2'b00;
    exp_err &= ~m;
    exp_ovf &= ~m;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start;
    logic [7:0] order [4];
    logic [1:0] exp_oe;
    order[0] = 8'h10; order[1] = 8'h20; order[2] = 8'h11; order[3] = 8'h21;

    repeat (3) tick();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_chan", out_chan, 0);
    check("rst_err", err_sticky, 0);
    check("rst_ovf", ovf_sticky, 0);
    check("rst_level", fifo_level, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    rst_n = 1'b1;
    repeat (5) tick();

    // Single byte and latency: 2 sync + 8 filter + 2 pipeline cycles after the raw stop edge
    send_frame(0, 8'h1C, 0, 0, 0);
    check("lat_cycles", rise_cyc - stop_cyc, 12);
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, 8'h1C);
    check("lat_chan", out_chan, 0);
    out_ready = 1'b1;
    repeat (3) tick();
    check("drain_valid", out_valid, 0);

    // Parity error, clear, then error coinciding with clear
    send_frame(1, 8'hA5, 1, 0, 0);
    check("par_err_lit", err_sticky[1], 1);
    check("par_err", err_sticky, exp_err);
    check("par_no_out", out_valid, 0);
    pulse_clr(2'b10);
    check("par_clr", err_sticky, exp_err);
    send_frame(1, 8'hA5, 1, 0, 1);
    check("set_wins", err_sticky[1], 1);
    pulse_clr(2'b10);
    send_frame(0, 8'h33, 0, 1, 0);
    check("stop_err", err_sticky, exp_err);
    pulse_clr(2'b01);
    check("stop_clr", err_sticky, 0);

    // Timeout after 4 data bits, then a clean frame
    send_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(0, 1'b1, 1'b0);
    repeat (4900) tick();
    check("tmo_early", err_sticky[0], 0);
    repeat (200) tick();
    exp_err[0] = 1'b1;
    check("tmo_err", err_sticky, exp_err);
    pulse_clr(2'b01);
    send_frame(0, 8'h55, 0, 0, 0);
    check("tmo_recover_err", err_sticky, 0);
    check("tmo_recover_byte", got_data[got_data.size()-1], 8'h55);

    // 3-cycle glitch low on clk with data low must not start a frame
    ps2_data_i[0] = 1'b0;
    ps2_clk_i[0]  = 1'b0;
    repeat (3) tick();
    ps2_clk_i[0]  = 1'b1;
    ps2_data_i[0] = 1'b1;
    repeat (40) tick();
    send_frame(0, 8'h3C, 0, 0, 0);
    check("glitch_err", err_sticky, 0);
    check("glitch_byte", got_data[got_data.size()-1], 8'h3C);

    // Overflow with a stalled consumer: register holds 0x01, FIFO 0x02..0x09, 0x0A dropped
    out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) send_frame(0, 8'(k), 0, 0, 0);
    check("ovf_level", fifo_level[3:0], 8);
    check("ovf_lit", ovf_sticky, 2'b01);
    check("ovf_model", ovf_sticky, exp_ovf);
`ifdef PS2_HUB_INHIBIT_EN
    exp_oe = 2'b01;
`else
    exp_oe = 2'b00;
`endif
    check("ovf_clk_oe", ps2_clk_oe, exp_oe);
    start = got_data.size();
    out_ready = 1'b1;
    repeat (20) tick();
    check("ovf_count", got_data.size() - start, 9);
    for (int k = 0; k < 9 && start + k < got_data.size(); k++)
      check("ovf_order", got_data[start+k], k + 1);
    pulse_clr(2'b01);
    check("ovf_clr", ovf_sticky, 0);

    // Round robin across two channels, no bubbles
    out_ready = 1'b0;
    fork
      begin
        send_frame(0, 8'h10, 0, 0, 0);
        send_frame(0, 8'h11, 0, 0, 0);
      end
      begin
        repeat (10) tick();
        send_frame(1, 8'h20, 0, 0, 0);
        send_frame(1, 8'h21, 0, 0, 0);
      end
    join
    start = got_data.size();
    out_ready = 1'b1;
    repeat (10) tick();
    check("rr_count", got_data.size() - start, 4);
    for (int k = 0; k < 4 && start + k < got_data.size(); k++) begin
      check("rr_order", got_data[start+k], order[k]);
      check("rr_no_bubble", got_cyc[start+k] - got_cyc[start], k);
    end

    check("model_empty", exp_q.size(), 0);
    check("final_err", err_sticky, exp_err);
    check("final_ovf", ovf_sticky, exp_ovf);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
